// File: rtl/i2c_slave_proto_fsm.sv
// I2C slave protocol engine: samples raw SCL/SDA, frames bytes, matches the device address
// and drives a byte-wide register file through an auto-incrementing pointer.
module i2c_slave_proto_fsm #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, REGADDR, REGACK, WRDATA, WRACK, RDDATA, RDACK, IGNORE
  } stateT;

  stateT      state;
  logic [1:0] sclSync, sdaSync;
  logic       sclPrev, sdaPrev;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic       isRead;
  logic       ackPhase;

  logic       sclNow, sdaNow;
  logic       sclRise, sclFall, startDet, stopDet;
  logic [7:0] rxByte, ptrInc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclSync <= 2'b11;
      sdaSync <= 2'b11;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[0], scl_i};
      sdaSync <= {sdaSync[0], sda_i};
      sclPrev <= sclSync[1];
      sdaPrev <= sdaSync[1];
    end
  end

  assign sclNow   = sclSync[1];
  assign sdaNow   = sdaSync[1];
  assign sclRise  = sclNow & ~sclPrev;
  assign sclFall  = ~sclNow & sclPrev;
  assign startDet = sclNow & sdaPrev & ~sdaNow;
  assign stopDet  = sclNow & ~sdaPrev & sdaNow;
  assign rxByte   = {shiftReg[6:0], sdaNow};
  assign ptrInc   = reg_addr + {7'd0, AUTO_INC};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitCnt    <= 3'd0;
      shiftReg  <= 8'd0;
      isRead    <= 1'b0;
      ackPhase  <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      // Bus conditions override whatever bit-level activity is in progress
      if (stopDet) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        ackPhase <= 1'b0;
      end else if (startDet) begin
        state    <= DEVADDR;
        bitCnt   <= 3'd0;
        sda_oe   <= 1'b0;
        ackPhase <= 1'b0;
      end else begin
        case (state)
          DEVADDR, REGADDR, WRDATA: if (sclRise) begin
            shiftReg <= rxByte;
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              if (state == DEVADDR) begin
                if (rxByte[7:1] == DEV_ADDR) begin
                  state  <= DEVACK;
                  busy   <= 1'b1;
                  isRead <= rxByte[0];
                end else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end else if (state == REGADDR) begin
                reg_addr <= rxByte;
                state    <= REGACK;
              end else begin
                reg_wdata <= rxByte;
                state     <= WRACK;
              end
            end
          end
          // First fall drives ACK (and strobes a write), second fall releases and moves on
          DEVACK, REGACK, WRACK: if (sclFall) begin
            if (!ackPhase) begin
              ackPhase <= 1'b1;
              sda_oe   <= 1'b1;
              reg_we   <= (state == WRACK);
            end else begin
              ackPhase <= 1'b0;
              sda_oe   <= 1'b0;
              bitCnt   <= 3'd0;
              if (state == WRACK) begin
                reg_addr <= ptrInc;
                state    <= WRDATA;
              end else if (state == REGACK) begin
                state <= WRDATA;
              end else if (isRead) begin
                shiftReg <= reg_rdata;
                sda_oe   <= ~reg_rdata[7];
                state    <= RDDATA;
              end else begin
                state <= REGADDR;
              end
            end
          end
          RDDATA: if (sclFall) begin
            if (bitCnt == 3'd7) begin
              sda_oe <= 1'b0;
              bitCnt <= 3'd0;
              state  <= RDACK;
            end else begin
              bitCnt   <= bitCnt + 3'd1;
              sda_oe   <= ~shiftReg[6];
              shiftReg <= {shiftReg[6:0], 1'b0};
            end
          end
          RDACK: begin
            if (sclRise) begin
              if (!sdaNow) begin
                reg_addr <= ptrInc;
                ackPhase <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= IGNORE;
              end
            end else if (sclFall && ackPhase) begin
              // Pointer moved at the ACK rise, so reg_rdata has long settled here
              ackPhase <= 1'b0;
              shiftReg <= reg_rdata;
              sda_oe   <= ~reg_rdata[7];
              bitCnt   <= 3'd0;
              state    <= RDDATA;
            end
          end
          IDLE, IGNORE: sda_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_proto_fsm.sv
// Bench for i2c_slave_proto_fsm: bit-banged master on an open-drain bus, a registered-read
// register file, a table of write transactions, corner sequences and random traffic.
`timescale 1ns/1ps
module tb_i2c_slave_proto_fsm;

  logic       clk = 1'b0, rst_n = 1'b0, sclM = 1'b1, sdaM = 1'b1, memInit = 1'b1;
  logic       sda_oe, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  wire        sdaLine = sdaM & ~sda_oe;

  i2c_slave_proto_fsm #(.DEV_ADDR(7'h3C), .AUTO_INC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(sclM), .sda_i(sdaLine), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initVal(input logic [7:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  // Register file with one-clock registered read
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= initVal(8'(i));
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= mem[reg_addr];
  end

  int weCount = 0, oeCount = 0;
  logic [7:0] weAddr[$], weData[$];
  always @(posedge clk) begin
    if (reg_we) begin
      weCount <= weCount + 1;
      weAddr.push_back(reg_addr);
      weData.push_back(reg_wdata);
    end
    if (sda_oe) oeCount <= oeCount + 1;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic q();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic busStart();
    sdaM = 1'b1; q(); sclM = 1'b1; q(); sdaM = 1'b0; q(); sclM = 1'b0; q();
  endtask

  task automatic busStop();
    sdaM = 1'b0; q(); sclM = 1'b1; q(); sdaM = 1'b1; q();
  endtask

  task automatic clockBit(input logic b, output logic seen);
    sdaM = b; q(); sclM = 1'b1; q(); seen = sdaLine; q(); sclM = 1'b0; q();
  endtask

  task automatic xferByte(input logic [7:0] tx, input logic ackBit,
                          output logic [7:0] rx, output logic ackSeen);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      clockBit(tx[i], b);
      rx[i] = b;
    end
    clockBit(ackBit, ackSeen);
  endtask

  task automatic writeTxn(input logic [7:0] dev, input logic [7:0] ptr, input int n,
                          input logic [7:0] dat [3], output int ackCnt, output logic busyMid);
    logic [7:0] rx;
    logic a;
    ackCnt = 0;
    busStart();
    xferByte(dev, 1'b1, rx, a); if (!a) ackCnt++;
    busyMid = busy;
    xferByte(ptr, 1'b1, rx, a); if (!a) ackCnt++;
    for (int k = 0; k < n; k++) begin
      xferByte(dat[k], 1'b1, rx, a); if (!a) ackCnt++;
    end
    busStop();
  endtask

  task automatic readTxn(input logic setPtr, input logic [7:0] ptr, input int n,
                         output logic [7:0] got [3], output int ackCnt);
    logic [7:0] rx;
    logic a;
    ackCnt = 0;
    for (int k = 0; k < 3; k++) got[k] = 8'h00;
    busStart();
    if (setPtr) begin
      xferByte(8'h78, 1'b1, rx, a); if (!a) ackCnt++;
      xferByte(ptr, 1'b1, rx, a); if (!a) ackCnt++;
      busStart();
    end
    xferByte(8'h79, 1'b1, rx, a); if (!a) ackCnt++;
    for (int k = 0; k < n; k++) begin
      xferByte(8'hFF, (k == n - 1), rx, a);
      got[k] = rx;
    end
    busStop();
  endtask

  typedef struct {
    logic [7:0] dev, ptr, d0, d1;
    logic       expAck;
    int         expWe;
    logic [7:0] expA0, expA1, expEnd;
  } vecT;

  vecT        vecs [4];
  logic [7:0] refMem [256];
  logic [7:0] refPtr, ptr, p, rx;
  logic [7:0] dat [3];
  logic [7:0] got [3];
  logic [6:0] dev7;
  logic       busyMid, isWr, match, a;
  int         ackCnt, we0, oe0, base, n, memErr;

  initial begin
    vecs[0] = '{8'h78, 8'h05, 8'hA5, 8'h5A, 1'b1, 2, 8'h05, 8'h06, 8'h07};
    vecs[1] = '{8'h7A, 8'h05, 8'h11, 8'h22, 1'b0, 0, 8'h00, 8'h00, 8'h07};
    vecs[2] = '{8'h78, 8'hFF, 8'h11, 8'h22, 1'b1, 2, 8'hFF, 8'h00, 8'h01};
    vecs[3] = '{8'h78, 8'h40, 8'h3C, 8'hC3, 1'b1, 2, 8'h40, 8'h41, 8'h42};
    for (int i = 0; i < 256; i++) refMem[i] = initVal(8'(i));
    refPtr = 8'h00;

    repeat (4) @(posedge clk);
    #1;
    chk("reset sda_oe", sda_oe, 0);
    chk("reset reg_we", reg_we, 0);
    chk("reset reg_addr", reg_addr, 0);
    chk("reset reg_wdata", reg_wdata, 0);
    chk("reset busy", busy, 0);
    memInit = 1'b0;
    rst_n = 1'b1;
    q();

    for (int v = 0; v < 4; v++) begin
      we0 = weCount; oe0 = oeCount; base = weAddr.size();
      dat[0] = vecs[v].d0; dat[1] = vecs[v].d1; dat[2] = 8'h00;
      writeTxn(vecs[v].dev, vecs[v].ptr, 2, dat, ackCnt, busyMid);
      $display("vec %0d dev=%02h ptr=%02h acks=%0d we=%0d end=%02h", v, vecs[v].dev,
               vecs[v].ptr, ackCnt, weCount - we0, reg_addr);
      chk($sformatf("vec%0d acks", v), ackCnt, vecs[v].expAck ? 4 : 0);
      chk($sformatf("vec%0d busy mid", v), busyMid, vecs[v].expAck);
      chk($sformatf("vec%0d we count", v), weCount - we0, vecs[v].expWe);
      chk($sformatf("vec%0d end ptr", v), reg_addr, vecs[v].expEnd);
      chk($sformatf("vec%0d busy end", v), busy, 0);
      if (vecs[v].expAck) begin
        chk($sformatf("vec%0d we0 addr", v), weAddr[base], vecs[v].expA0);
        chk($sformatf("vec%0d we0 data", v), weData[base], vecs[v].d0);
        chk($sformatf("vec%0d we1 addr", v), weAddr[base + 1], vecs[v].expA1);
        chk($sformatf("vec%0d we1 data", v), weData[base + 1], vecs[v].d1);
        refMem[vecs[v].expA0] = vecs[v].d0;
        refMem[vecs[v].expA1] = vecs[v].d1;
      end else begin
        chk($sformatf("vec%0d sda_oe quiet", v), oeCount - oe0, 0);
      end
      refPtr = vecs[v].expEnd;
    end

    // Write pointer then repeated-START read of two bytes (ACK, NACK)
    we0 = weCount;
    readTxn(1'b1, 8'h05, 2, got, ackCnt);
    $display("read2 ptr=05 got %02h %02h acks=%0d", got[0], got[1], ackCnt);
    chk("read2 acks", ackCnt, 3);
    chk("read2 byte0", got[0], 8'hA5);
    chk("read2 byte1", got[1], 8'h5A);
    chk("read2 no we", weCount - we0, 0);
    chk("read2 sda_oe", sda_oe, 0);
    chk("read2 end ptr", reg_addr, 8'h06);
    refPtr = 8'h06;

    // Partial data byte then STOP: nothing written, pointer stays at 0x03
    we0 = weCount;
    busStart();
    xferByte(8'h78, 1'b1, rx, a);
    xferByte(8'h03, 1'b1, rx, a);
    for (int i = 0; i < 4; i++) clockBit(1'(i[0]), a);
    busStop();
    $display("partial-stop ptr=%02h we=%0d busy=%0d", reg_addr, weCount - we0, busy);
    chk("partial-stop no we", weCount - we0, 0);
    chk("partial-stop ptr", reg_addr, 8'h03);
    chk("partial-stop sda_oe", sda_oe, 0);
    chk("partial-stop busy", busy, 0);

    // Partial data byte then repeated START straight into a read
    we0 = weCount;
    busStart();
    xferByte(8'h78, 1'b1, rx, a);
    xferByte(8'h10, 1'b1, rx, a);
    for (int i = 0; i < 4; i++) clockBit(1'b0, a);
    busStart();
    xferByte(8'h79, 1'b1, rx, a);
    chk("partial-sr dev ack", a, 0);
    xferByte(8'hFF, 1'b1, rx, a);
    busStop();
    $display("partial-sr read %02h we=%0d ptr=%02h", rx, weCount - we0, reg_addr);
    chk("partial-sr data", rx, refMem[8'h10]);
    chk("partial-sr no we", weCount - we0, 0);
    chk("partial-sr ptr", reg_addr, 8'h10);

    // Asynchronous reset while the slave is driving a 0 data bit (0xA5, bit 6)
    busStart();
    xferByte(8'h78, 1'b1, rx, a);
    xferByte(8'h05, 1'b1, rx, a);
    busStart();
    xferByte(8'h79, 1'b1, rx, a);
    clockBit(1'b1, a);
    chk("async-rst oe before", sda_oe, 1);
    rst_n = 1'b0;
    #2;
    $display("async-rst sda_oe=%0d ptr=%02h busy=%0d", sda_oe, reg_addr, busy);
    chk("async-rst sda_oe", sda_oe, 0);
    chk("async-rst ptr", reg_addr, 0);
    chk("async-rst busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q();
    busStop();
    refPtr = 8'h00;
    readTxn(1'b0, 8'h00, 1, got, ackCnt);
    $display("post-rst read got %02h acks=%0d", got[0], ackCnt);
    chk("post-rst ack", ackCnt, 1);
    chk("post-rst data", got[0], refMem[8'h00]);
    chk("post-rst ptr", reg_addr, 8'h00);

    // Random traffic against a transaction-level model of the register file
    for (int t = 0; t < 12; t++) begin
      isWr = 1'($urandom_range(0, 1));
      ptr  = ($urandom_range(0, 3) == 0) ? 8'hFE + 8'($urandom_range(0, 1)) : 8'($urandom);
      n    = $urandom_range(1, 3);
      we0  = weCount;
      if (isWr) begin
        match = ($urandom_range(0, 3) != 0);
        dev7  = match ? 7'h3C : 7'($urandom);
        if (!match && dev7 == 7'h3C) dev7 = 7'h3D;
        for (int k = 0; k < 3; k++) dat[k] = 8'($urandom);
        writeTxn({dev7, 1'b0}, ptr, n, dat, ackCnt, busyMid);
        $display("rand %0d W dev=%02h ptr=%02h n=%0d acks=%0d we=%0d end=%02h", t, dev7,
                 ptr, n, ackCnt, weCount - we0, reg_addr);
        if (match) begin
          p = ptr;
          for (int k = 0; k < n; k++) begin
            refMem[p] = dat[k];
            p = p + 8'd1;
          end
          refPtr = p;
        end
        chk($sformatf("rand%0d acks", t), ackCnt, match ? n + 2 : 0);
        chk($sformatf("rand%0d we count", t), weCount - we0, match ? n : 0);
      end else begin
        readTxn(1'b1, ptr, n, got, ackCnt);
        $display("rand %0d R ptr=%02h n=%0d got %02h %02h %02h end=%02h", t, ptr, n,
                 got[0], got[1], got[2], reg_addr);
        chk($sformatf("rand%0d acks", t), ackCnt, 3);
        for (int k = 0; k < n; k++)
          chk($sformatf("rand%0d rd%0d", t, k), got[k], refMem[ptr + 8'(k)]);
        chk($sformatf("rand%0d no we", t), weCount - we0, 0);
        refPtr = ptr + 8'(n - 1);
      end
      chk($sformatf("rand%0d end ptr", t), reg_addr, refPtr);
      chk($sformatf("rand%0d busy", t), busy, 0);
    end

    memErr = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) memErr++;
    chk("register image", memErr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
